// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and types for the convolutional encoder framer
package conv_pkg;
  localparam int K_DEF = 3;
  localparam logic [K_DEF-1:0] G0_DEF = 3'b111;
  localparam logic [K_DEF-1:0] G1_DEF = 3'b101;
  localparam int FRAME_LEN_DEF = 256;
  typedef logic [1:0] symbol_t;
  typedef enum logic [1:0] {IDLE, DATA, TAIL} fr_state_t;
endpackage

// File: rtl/conv_core.sv
// conv_core: rate-1/2 shift register and generator parities, symbol registered on adv
module conv_core
  import conv_pkg::*;
#(
  parameter int K = K_DEF,
  parameter logic [K-1:0] G0 = K'(G0_DEF),
  parameter logic [K-1:0] G1 = K'(G1_DEF)
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    adv,
  input  logic    bit_i,
  output symbol_t sym_o
);
  logic [K-2:0] st;
  logic [K-1:0] sr;
  assign sr = {bit_i, st};
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '0;
      sym_o <= '0;
    end else if (adv) begin
      st <= sr[K-1:1];
      sym_o <= {^(sr & G0), ^(sr & G1)};
    end
  end
endmodule

// File: rtl/conv_encoder_framer.sv
// conv_encoder_framer: framed rate-1/2 convolutional encoder with zero tail per frame
module conv_encoder_framer
  import conv_pkg::*;
#(
  parameter int K = K_DEF,
  parameter logic [K-1:0] G0 = K'(G0_DEF),
  parameter logic [K-1:0] G1 = K'(G1_DEF),
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        d_in,
  output logic        ready_o,
  output logic        valid_o,
  output symbol_t     d_out,
  output logic        sof_o,
  output logic        eof_o,
  output logic [15:0] frame_ct_o,
  output logic [15:0] drop_ct_o
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
  fr_state_t st;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic in_tail, xfer, last_tail;
  assign in_tail = st == TAIL;
  assign ready_o = !in_tail;
  assign xfer = enable_i && ready_o;
  assign last_tail = in_tail && tcnt == TW'(K - 2);
  // tail cycles feed zeros so the trellis returns to state 0
  conv_core #(.K(K), .G0(G0), .G1(G1)) u_core (
    .clk(clk),
    .rst(rst),
    .adv(xfer || in_tail),
    .bit_i(d_in && !in_tail),
    .sym_o(d_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      valid_o <= 1'b0;
      sof_o <= 1'b0;
      eof_o <= 1'b0;
      frame_ct_o <= '0;
      drop_ct_o <= '0;
    end else begin
      valid_o <= xfer || in_tail;
      sof_o <= xfer && st == IDLE;
      eof_o <= last_tail;
      if (enable_i && !ready_o && drop_ct_o != '1) drop_ct_o <= drop_ct_o + 1'b1;
      if (xfer) begin
        cnt <= cnt + 1'b1;
        st <= cnt == CW'(FRAME_LEN - 1) ? TAIL : DATA;
        tcnt <= '0;
      end
      if (in_tail) begin
        tcnt <= tcnt + 1'b1;
        if (last_tail) begin
          st <= IDLE;
          cnt <= '0;
          frame_ct_o <= frame_ct_o + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_encoder_framer.sv
// tb_conv_encoder_framer: vector table, corner sequences and randomized model check
module tb_conv_encoder_framer;
  import conv_pkg::*;
  localparam int K = 3;
  logic [K-1:0] g0 = 3'b111;
  logic [K-1:0] g1 = 3'b101;
  logic clk = 0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, en_a, d_a, ready_a, valid_a, sof_a, eof_a;
  logic rst_b, en_b, d_b, ready_b, valid_b, sof_b, eof_b;
  logic [1:0] dout_a, dout_b;
  logic [15:0] fct_a, dct_a, fct_b, dct_b;

  conv_encoder_framer #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(4)) dut_a (
    .clk(clk), .rst(rst_a), .enable_i(en_a), .d_in(d_a), .ready_o(ready_a), .valid_o(valid_a),
    .d_out(dout_a), .sof_o(sof_a), .eof_o(eof_a), .frame_ct_o(fct_a), .drop_ct_o(dct_a));
  conv_encoder_framer #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(256)) dut_b (
    .clk(clk), .rst(rst_b), .enable_i(en_b), .d_in(d_b), .ready_o(ready_b), .valid_o(valid_b),
    .d_out(dout_b), .sof_o(sof_b), .eof_o(eof_b), .frame_ct_o(fct_b), .drop_ct_o(dct_b));

  logic [3:0] q_a[$], q_b[$], exp_q[$];
  int c_a[$];
  always @(negedge clk) begin
    if (valid_a) begin
      q_a.push_back({sof_a, eof_a, dout_a});
      c_a.push_back(cyc);
    end
    if (valid_b) q_b.push_back({sof_b, eof_b, dout_b});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [15:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      en_a = 1;
      d_a = bits[n-1-i];
      @(posedge clk); #1;
      if (i < n - 1) begin
        en_a = 0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    en_a = 0;
  endtask

  task automatic wait_eof_a;
    int t;
    t = 0;
    while (!eof_a && t < 20) begin @(posedge clk); #1; t++; end
    chk("eof_seen", eof_a, 1);
    @(negedge clk); #1;
  endtask

  task automatic cmp_a(input string name, input logic [23:0] syms, input int nsym);
    chk({name, "_len"}, q_a.size(), nsym);
    for (int j = 0; j < nsym && j < q_a.size(); j++)
      chk(name, q_a[j], {j % 6 == 0, j % 6 == 5, syms[2*(nsym-1-j) +: 2]});
  endtask

  // reference: each symbol is the generator-weighted parity of the newest K frame bits
  task automatic model_push(input bit b[256]);
    bit x[$];
    logic p0, p1;
    foreach (b[k]) x.push_back(b[k]);
    repeat (K - 1) x.push_back(1'b0);
    for (int n = 0; n < x.size(); n++) begin
      p0 = 0;
      p1 = 0;
      for (int j = 0; j < K && j <= n; j++) begin
        p0 ^= g0[K-1-j] & x[n-j];
        p1 ^= g1[K-1-j] & x[n-j];
      end
      exp_q.push_back({n == 0, n == x.size() - 1, p0, p1});
    end
  endtask

  typedef struct {logic [3:0] bits; int gap; logic [11:0] syms;} vec_t;
  vec_t vt[5];
  bit fb[256];
  int bi, exp_drop;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'b1011, 0, 12'b11_10_00_01_01_11};
    vt[1] = '{4'b1011, 2, 12'b11_10_00_01_01_11};
    vt[2] = '{4'b0000, 1, 12'b00_00_00_00_00_00};
    vt[3] = '{4'b1111, 0, 12'b11_01_10_10_01_11};
    vt[4] = '{4'b0100, 3, 12'b00_11_10_11_00_00};
    rst_a = 1; rst_b = 1; en_a = 0; en_b = 0; d_a = 0; d_b = 0;
    repeat (2) @(posedge clk); #1;
    rst_a = 0; rst_b = 0;
    chk("reset_a", {ready_a, valid_a, sof_a, eof_a, dout_a, fct_a, dct_a}, {4'b1000, 2'b00, 32'h0});
    chk("reset_b", {ready_b, valid_b, sof_b, eof_b, dout_b, fct_b, dct_b}, {4'b1000, 2'b00, 32'h0});

    for (int v = 0; v < 5; v++) begin
      q_a.delete(); c_a.delete();
      drive_a(16'(vt[v].bits), 4, vt[v].gap);
      wait_eof_a();
      cmp_a($sformatf("vec%0d", v), 24'(vt[v].syms), 6);
      chk($sformatf("vec%0d_span", v), c_a[5] - c_a[0], 5 + 3 * vt[v].gap);
      chk($sformatf("vec%0d_frame_ct", v), fct_a, v + 1);
    end

    q_a.delete(); c_a.delete();
    drive_a(16'b1011_00_1011, 10, 0);
    wait_eof_a();
    cmp_a("b2b", {12'b11_10_00_01_01_11, 12'b11_10_00_01_01_11}, 12);
    chk("b2b_contig", c_a[11] - c_a[0], 11);
    chk("b2b_drops", dct_a, 2);
    chk("b2b_frame_ct", fct_a, 7);

    drive_a(16'b10, 2, 0);
    rst_a = 1;
    @(posedge clk); #1;
    rst_a = 0;
    chk("midreset", {ready_a, valid_a, sof_a, eof_a, dout_a, fct_a, dct_a}, {4'b1000, 2'b00, 32'h0});
    q_a.delete(); c_a.delete();
    drive_a(16'b1011, 4, 0);
    wait_eof_a();
    cmp_a("post_reset", 24'(12'b11_10_00_01_01_11), 6);
    chk("post_reset_frame_ct", fct_a, 1);

    force dut_a.frame_ct_o = 16'hFFFF;
    force dut_a.drop_ct_o = 16'hFFFE;
    #1;
    release dut_a.frame_ct_o;
    release dut_a.drop_ct_o;
    drive_a(16'b1011_00, 6, 0);
    wait_eof_a();
    chk("wrap_frame_ct", fct_a, 0);
    chk("sat_drop_ct", dct_a, 16'hFFFF);
    drive_a(16'b1011_00, 6, 0);
    wait_eof_a();
    chk("wrap_frame_ct2", fct_a, 1);
    chk("sat_drop_hold", dct_a, 16'hFFFF);

    exp_drop = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 256; k++) fb[k] = 1'($urandom);
      model_push(fb);
      bi = 0;
      while (bi < 256) begin
        en_b = $urandom_range(0, 3) != 0;
        d_b = en_b ? fb[bi] : 1'($urandom);
        chk("ready_data", ready_b, 1);
        @(posedge clk); #1;
        if (en_b) bi++;
      end
      repeat (K - 1) begin
        en_b = 1'($urandom);
        d_b = 1'($urandom);
        chk("ready_tail", ready_b, 0);
        if (en_b) exp_drop++;
        @(posedge clk); #1;
      end
    end
    en_b = 0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    chk("rand_len", q_b.size(), exp_q.size());
    for (int j = 0; j < q_b.size() && j < exp_q.size(); j++)
      chk($sformatf("rand_sym%0d", j), q_b[j], exp_q[j]);
    chk("rand_frame_ct", fct_b, 3);
    chk("rand_drop_ct", dct_b, exp_drop);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
